// File: rtl/pac_pair_scheduler_pkg.sv
// Shared definitions for the PAC pair scheduler: FSM states, engine class
// codes and the canonical oscillator-pair index map.
package pac_pair_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCommit,
        StDone
    } state_e;

    // Engine classification codes
    localparam logic [1:0] CLASS_ATTRACT  = 2'b00;
    localparam logic [1:0] CLASS_TRANSIT  = 2'b01;
    localparam logic [1:0] CLASS_BOUNDARY = 2'b10;

    // Canonical pair indices; the scheduler walks them in this order
    localparam int unsigned PAIR_THETA_ALPHA      = 0;
    localparam int unsigned PAIR_THETA_BETA_LOW   = 1;
    localparam int unsigned PAIR_ALPHA_BETA_LOW   = 2;
    localparam int unsigned PAIR_ALPHA_BETA_HIGH  = 3;
    localparam int unsigned PAIR_BETA_LOW_GAMMA   = 4;
    localparam int unsigned PAIR_BETA_HIGH_GAMMA  = 5;
    localparam int unsigned PAIR_THETA_GAMMA_FAST = 6;
    localparam int unsigned PAIR_ALPHA_GAMMA_FAST = 7;
    localparam int unsigned PAIR_SR_F0_F2         = 8;
    localparam int unsigned PAIR_THETA_GAMMA      = 9;
    localparam int unsigned NUM_CANON_PAIRS       = 10;

endpackage

// File: rtl/pac_lowest_set.sv
// Priority encoder: index of the lowest set bit of vec, valid when any bit is set.
module pac_lowest_set #(
    parameter int unsigned N = 10,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan downwards so the lowest set bit is the last one to assign idx
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pac_pair_scheduler.sv
// Time-multiplexes one PAC compute engine across all oscillator pairs.
// Each frame strobe walks the masked pairs in ascending order through a
// req/ack handshake and commits results into a register bank.
// Optional feature: define PAC_SMOOTH_EN to make each bank write an EMA update.
module pac_pair_scheduler
    import pac_pair_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH        = 18,
    parameter int unsigned FRAC         = 14,
    parameter int unsigned NUM_PAIRS    = 10,
    parameter int unsigned PAIR_W       = 4,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned SMOOTH_SHIFT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   enable,
    input  logic [NUM_PAIRS-1:0]   pair_mask,
    input  logic                   err_clr,
    output logic                   eng_req,
    output logic [PAIR_W-1:0]      eng_pair,
    input  logic                   eng_ack,
    input  logic [WIDTH-1:0]       eng_pac,
    input  logic [1:0]             eng_class,
    output logic [NUM_PAIRS*WIDTH-1:0] pac_flat,
    output logic [NUM_PAIRS*2-1:0] class_flat,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun,
    output logic                   timeout_err
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    // Reject configurations that cannot index every pair or hold the Q format
    if (FRAC >= WIDTH || SMOOTH_SHIFT >= WIDTH || NUM_PAIRS > (32'd1 << PAIR_W)
        || TIMEOUT == 0) begin : g_param_check
        $error("pac_pair_scheduler: invalid parameter combination");
    end

    state_e                 state_q, state_d;
    logic [NUM_PAIRS-1:0]   pending_q, pending_d, cur_onehot;
    logic [PAIR_W-1:0]      cur_q, cur_d, low_idx;
    logic                   low_valid;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic                   req_q, req_d;
    logic                   ack_q, ack_d;
    logic [WIDTH-1:0]       pac_cap_q, pac_cap_d;
    logic [1:0]             class_cap_q, class_cap_d;
    logic                   bank_we;
    logic                   timeout_set;
    logic [WIDTH-1:0]       bank_wdata;
    logic [WIDTH-1:0]       bank_q [NUM_PAIRS];
    logic [1:0]             cls_q [NUM_PAIRS];
    logic                   overrun_q, timeout_q;

    pac_lowest_set #(
        .N (NUM_PAIRS),
        .W (PAIR_W)
    ) u_lowest_set (
        .vec   (pending_q),
        .idx   (low_idx),
        .valid (low_valid)
    );

    // One-hot of the pair currently in flight, used to retire it from pending
    always_comb begin
        cur_onehot = '0;
        for (int i = 0; i < int'(NUM_PAIRS); i++) begin
            cur_onehot[i] = (cur_q == PAIR_W'(i));
        end
    end

    // Next-state and handshake control
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cur_d       = cur_q;
        tcnt_d      = tcnt_q;
        req_d       = req_q;
        ack_d       = ack_q;
        pac_cap_d   = pac_cap_q;
        class_cap_d = class_cap_q;
        bank_we     = 1'b0;
        timeout_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clk_en && enable) begin
                    if (pair_mask != '0) begin
                        pending_d = pair_mask;
                        state_d   = StIssue;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                if (low_valid) begin
                    cur_d   = low_idx;
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                    ack_d   = 1'b0;
                    state_d = StWait;
                end else begin
                    state_d = StDone;
                end
            end
            StWait: begin
                if (eng_ack) begin
                    pac_cap_d   = eng_pac;
                    class_cap_d = eng_class;
                    ack_d       = 1'b1;
                    req_d       = 1'b0;
                    state_d     = StCommit;
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    req_d       = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = StCommit;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            StCommit: begin
                // A timed-out pair is retired without touching the bank
                bank_we   = ack_q;
                pending_d = pending_q & ~cur_onehot;
                state_d   = (pending_d == '0) ? StDone : StIssue;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            cur_q       <= '0;
            tcnt_q      <= '0;
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            pac_cap_q   <= '0;
            class_cap_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_q       <= cur_d;
            tcnt_q      <= tcnt_d;
            req_q       <= req_d;
            ack_q       <= ack_d;
            pac_cap_q   <= pac_cap_d;
            class_cap_q <= class_cap_d;
        end
    end

`ifdef PAC_SMOOTH_EN
    logic [WIDTH-1:0]        bank_old;
    logic signed [WIDTH:0]   ema_diff, ema_step;
    logic signed [WIDTH+1:0] ema_sum;

    // EMA toward the new sample; arithmetic shift floors, then clamp to range
    always_comb begin
        bank_old = '0;
        for (int i = 0; i < int'(NUM_PAIRS); i++) begin
            if (cur_q == PAIR_W'(i)) begin
                bank_old = bank_q[i];
            end
        end
        ema_diff = $signed({1'b0, pac_cap_q}) - $signed({1'b0, bank_old});
        ema_step = ema_diff >>> SMOOTH_SHIFT;
        ema_sum  = $signed({2'b00, bank_old}) + $signed({ema_step[WIDTH], ema_step});
        if (ema_sum[WIDTH+1]) begin
            bank_wdata = '0;
        end else if (ema_sum[WIDTH]) begin
            bank_wdata = '1;
        end else begin
            bank_wdata = ema_sum[WIDTH-1:0];
        end
    end
`else
    // Direct write of the engine result
    always_comb begin
        bank_wdata = pac_cap_q;
    end
`endif

    // Result and class bank, written only on the ack path of COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_PAIRS); i++) begin
                bank_q[i] <= '0;
                cls_q[i]  <= '0;
            end
        end else if (bank_we) begin
            for (int i = 0; i < int'(NUM_PAIRS); i++) begin
                if (cur_q == PAIR_W'(i)) begin
                    bank_q[i] <= bank_wdata;
                    cls_q[i]  <= class_cap_q;
                end
            end
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (clk_en && busy) begin
                overrun_q <= 1'b1;
            end else if (err_clr) begin
                overrun_q <= 1'b0;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (err_clr) begin
                timeout_q <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_PAIRS); k++) begin : g_flat
        assign pac_flat[k*WIDTH +: WIDTH] = bank_q[k];
        assign class_flat[k*2 +: 2]       = cls_q[k];
    end

    assign eng_req     = req_q;
    assign eng_pair    = cur_q;
    assign frame_done  = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pac_pair_scheduler.sv
// Self-checking bench for pac_pair_scheduler: table-driven frames, corner-case
// sequences and randomized frames against a frame-level reference model.
module tb_pac_pair_scheduler;

    localparam int WIDTH        = 18;
    localparam int FRAC         = 14;
    localparam int NUM_PAIRS    = 10;
    localparam int PAIR_W       = 4;
    localparam int TIMEOUT      = 15;
    localparam int SMOOTH_SHIFT = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       clk_en;
    logic                       enable;
    logic [NUM_PAIRS-1:0]       pair_mask;
    logic                       err_clr;
    logic                       eng_req;
    logic [PAIR_W-1:0]          eng_pair;
    logic                       eng_ack;
    logic [WIDTH-1:0]           eng_pac;
    logic [1:0]                 eng_class;
    logic [NUM_PAIRS*WIDTH-1:0] pac_flat;
    logic [NUM_PAIRS*2-1:0]     class_flat;
    logic                       frame_done;
    logic                       busy;
    logic                       overrun;
    logic                       timeout_err;

    pac_pair_scheduler #(
        .WIDTH        (WIDTH),
        .FRAC         (FRAC),
        .NUM_PAIRS    (NUM_PAIRS),
        .PAIR_W       (PAIR_W),
        .TIMEOUT      (TIMEOUT),
        .SMOOTH_SHIFT (SMOOTH_SHIFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .enable      (enable),
        .pair_mask   (pair_mask),
        .err_clr     (err_clr),
        .eng_req     (eng_req),
        .eng_pair    (eng_pair),
        .eng_ack     (eng_ack),
        .eng_pac     (eng_pac),
        .eng_class   (eng_class),
        .pac_flat    (pac_flat),
        .class_flat  (class_flat),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_bank [NUM_PAIRS];
    logic [1:0]       m_cls  [NUM_PAIRS];
    bit               m_to;
    bit               m_ov;

    // Engine behaviour per pair: lat = WAIT cycles to ack (0 = never acks)
    int               lat_tab [NUM_PAIRS];
    logic [WIDTH-1:0] pac_tab [NUM_PAIRS];
    logic [1:0]       cls_tab [NUM_PAIRS];

    typedef struct {
        logic [NUM_PAIRS-1:0] mask;
        int                   lat;
        int                   exp_done;
        bit                   exp_to;
    } vec_t;

    vec_t tab [7];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] bank_next(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] pac_v);
`ifdef PAC_SMOOTH_EN
        int d;
        int n;
        d = int'(pac_v) - int'(old_v);
        n = int'(old_v) + (d >>> SMOOTH_SHIFT);
        if (n < 0) n = 0;
        if (n > (1 << WIDTH) - 1) n = (1 << WIDTH) - 1;
        return WIDTH'(n);
`else
        return pac_v;
`endif
    endfunction

    function automatic bit acks(input int k);
        return lat_tab[k] != 0 && lat_tab[k] <= TIMEOUT;
    endfunction

    // Frame length in cycles from the strobe to frame_done
    function automatic int frame_len(input logic [NUM_PAIRS-1:0] mask);
        int s;
        s = 1;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (mask[k]) s += 2 + (acks(k) ? lat_tab[k] : TIMEOUT);
        end
        return s;
    endfunction

    function automatic logic [191:0] model_pac();
        logic [191:0] r;
        r = '0;
        for (int k = 0; k < NUM_PAIRS; k++) r[k*WIDTH +: WIDTH] = m_bank[k];
        return r;
    endfunction

    function automatic logic [191:0] model_cls();
        logic [191:0] r;
        r = '0;
        for (int k = 0; k < NUM_PAIRS; k++) r[k*2 +: 2] = m_cls[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NUM_PAIRS; k++) begin
            m_bank[k] = '0;
            m_cls[k]  = '0;
        end
        m_to = 0;
        m_ov = 0;
    endtask

    task automatic drive_idle();
        clk_en    = 1'b0;
        err_clr   = 1'b0;
        enable    = 1'b1;
        eng_ack   = 1'b0;
        eng_pac   = '0;
        eng_class = '0;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ov = 0;
        m_to = 0;
        check("err_clr flags", {overrun, timeout_err}, 2'b00);
    endtask

    // Runs one frame with the bench acting as engine; cycle 0 is the strobe cycle
    task automatic run_frame(input string name, input logic [NUM_PAIRS-1:0] mask,
                             input int exp_done, input int strobe_at, input int clr_at,
                             input int abort_at, input bit noise);
        int  exp_q[$];
        int  cur;
        int  wcnt;
        int  seen_at;
        bit  req_prev;
        bit  aborted;
        for (int k = 0; k < NUM_PAIRS; k++) if (mask[k]) exp_q.push_back(k);
        if (abort_at < 0) begin
            for (int k = 0; k < NUM_PAIRS; k++) begin
                if (mask[k]) begin
                    if (acks(k)) begin
                        m_bank[k] = bank_next(m_bank[k], pac_tab[k]);
                        m_cls[k]  = cls_tab[k];
                    end else begin
                        m_to = 1;
                    end
                end
            end
        end
        @(negedge clk);
        enable    = 1'b1;
        pair_mask = mask;
        clk_en    = 1'b1;
        cur       = -1;
        wcnt      = 0;
        seen_at   = -1;
        req_prev  = 0;
        aborted   = 0;
        for (int cyc = 1; cyc <= exp_done + 20; cyc++) begin
            @(negedge clk);
            clk_en  = (cyc == strobe_at);
            err_clr = (cyc == clr_at);
            if (cyc == strobe_at) m_ov = 1;
            else if (cyc == clr_at) begin
                m_ov = 0;
                m_to = 0;
            end
            if (noise) begin
                enable    = 1'($urandom_range(0, 1));
                pair_mask = NUM_PAIRS'($urandom);
            end
            if (cyc == 1) check({name, " busy@1"}, busy, 1'b1);
            if (seen_at >= 0) begin
                check({name, " done pulse width"}, {frame_done, busy}, 2'b00);
                break;
            end
            if (frame_done) begin
                check({name, " done cycle"}, cyc, exp_done);
                seen_at = cyc;
            end
            if (eng_req) begin
                if (!req_prev) begin
                    cur  = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    wcnt = 0;
                    check({name, " eng_pair"}, eng_pair, cur);
                end else begin
                    wcnt++;
                    if (eng_pair !== PAIR_W'(cur)) check({name, " eng_pair held"}, eng_pair, cur);
                end
                eng_ack   = (cur >= 0) && lat_tab[cur] != 0 && wcnt == lat_tab[cur] - 1;
                eng_pac   = (eng_ack && cur >= 0) ? pac_tab[cur] : WIDTH'($urandom);
                eng_class = (eng_ack && cur >= 0) ? cls_tab[cur] : 2'($urandom);
            end else begin
                eng_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                eng_pac   = WIDTH'($urandom);
                eng_class = 2'($urandom);
            end
            req_prev = eng_req;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({name, " async reset bank"}, pac_flat, '0);
                check({name, " async reset ctl"},
                      {eng_req, eng_pair, class_flat, frame_done, busy, overrun, timeout_err}, '0);
                model_clear();
                aborted = 1;
                break;
            end
        end
        drive_idle();
        if (aborted) begin
            repeat (2) begin
                @(negedge clk);
                check({name, " no done in reset"}, frame_done, 1'b0);
            end
            rst_n = 1'b1;
        end else begin
            if (seen_at < 0) check({name, " frame_done seen"}, 1'b0, 1'b1);
            check({name, " all pairs requested"}, exp_q.size(), 0);
            check({name, " pac_flat"}, pac_flat, model_pac());
            check({name, " class_flat"}, class_flat, model_cls());
            check({name, " flags"}, {overrun, timeout_err}, {m_ov, m_to});
        end
    endtask

    task automatic set_engine(input int lat, input int base, input int salt);
        for (int k = 0; k < NUM_PAIRS; k++) begin
            lat_tab[k] = lat;
            pac_tab[k] = WIDTH'(base + k);
            cls_tab[k] = 2'((k + salt) % 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] old2;
        logic [WIDTH-1:0] smooth_exp [3];
        logic [NUM_PAIRS-1:0] rmask;
        int r;

        tab[0] = '{mask: 10'h3FF, lat: 1,  exp_done: 31, exp_to: 1'b0};
        tab[1] = '{mask: 10'h011, lat: 3,  exp_done: 11, exp_to: 1'b0};
        tab[2] = '{mask: 10'h000, lat: 1,  exp_done: 1,  exp_to: 1'b0};
        tab[3] = '{mask: 10'h200, lat: 1,  exp_done: 4,  exp_to: 1'b0};
        tab[4] = '{mask: 10'h001, lat: 15, exp_done: 18, exp_to: 1'b0};
        tab[5] = '{mask: 10'h002, lat: 0,  exp_done: 18, exp_to: 1'b1};
        tab[6] = '{mask: 10'h155, lat: 2,  exp_done: 21, exp_to: 1'b0};

        rst_n     = 1'b0;
        pair_mask = '0;
        drive_idle();
        model_clear();
        repeat (3) @(negedge clk);
        check("reset bank", pac_flat, '0);
        check("reset ctl", {eng_req, eng_pair, class_flat, frame_done, busy, overrun, timeout_err},
              '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", {busy, frame_done}, 2'b00);

        for (int i = 0; i < 7; i++) begin
            set_engine(tab[i].lat, 16384 + 32 * i, i);
            run_frame($sformatf("vec%0d", i), tab[i].mask, tab[i].exp_done, -1, -1, -1, 0);
            check($sformatf("vec%0d timeout_err", i), timeout_err, tab[i].exp_to);
            clear_errs();
        end

        // Pair 2 never acknowledged: bank[2] must survive, frame still completes
        set_engine(1, 20000, 0);
        lat_tab[2] = 0;
        old2 = m_bank[2];
        run_frame("timeout pair2", 10'h007, 24, -1, -1, -1, 0);
        check("timeout pair2 flag", timeout_err, 1'b1);
        check("timeout pair2 bank kept", pac_flat[2*WIDTH +: WIDTH], old2);
        clear_errs();

        // Strobe during a frame: overrun, no queued frame
        set_engine(1, 30000, 1);
        run_frame("overrun", 10'h3FF, 31, 5, -1, -1, 0);
        repeat (4) @(negedge clk);
        check("overrun no extra frame", {busy, frame_done}, 2'b00);
        check("overrun sticky", overrun, 1'b1);
        clear_errs();
        run_frame("overrun set wins", 10'h3FF, 31, 5, 5, -1, 0);
        check("set beats clear", overrun, 1'b1);
        run_frame("overrun later clr", 10'h00F, 13, 3, 8, -1, 0);
        check("later clear", overrun, 1'b0);
        clear_errs();

        // Reset in cycle 4 of a frame, then a clean full frame
        set_engine(1, 40000, 2);
        run_frame("abort", 10'h3FF, 31, -1, -1, 4, 0);
        set_engine(1, 16384, 0);
        run_frame("after abort", 10'h3FF, 31, -1, -1, -1, 0);

        // Three frames of constant 16384 into pair 0 from a cleared bank
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
`ifdef PAC_SMOOTH_EN
        smooth_exp[0] = 18'd4096;
        smooth_exp[1] = 18'd7168;
        smooth_exp[2] = 18'd9472;
`else
        smooth_exp[0] = 18'd16384;
        smooth_exp[1] = 18'd16384;
        smooth_exp[2] = 18'd16384;
`endif
        set_engine(1, 16384, 0);
        for (int f = 0; f < 3; f++) begin
            pac_tab[0] = 18'd16384;
            run_frame($sformatf("smooth%0d", f), 10'h001, 4, -1, -1, -1, 0);
            check($sformatf("smooth frame %0d", f), pac_flat[WIDTH-1:0], smooth_exp[f]);
        end

        // Randomized frames with noise on idle-time ack, enable and mask
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < NUM_PAIRS; k++) begin
                r = $urandom_range(0, 9);
                lat_tab[k] = (r == 0) ? 0 : (r == 1) ? 16 : (r == 2) ? 15 : $urandom_range(1, 4);
                pac_tab[k] = WIDTH'($urandom);
                cls_tab[k] = 2'($urandom_range(0, 2));
            end
            rmask = ($urandom_range(0, 5) == 0) ? '0 : NUM_PAIRS'($urandom);
            run_frame($sformatf("rand%0d", f), rmask, frame_len(rmask), -1, -1, -1, 1);
            clear_errs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
